// File: rtl/seq_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seq_pkg
// Purpose  : Shared widths and fetch state encoding for the sequencer fetch unit.
// Revision : 1.0
// ============================================================================
package seq_pkg;

    localparam int INST_W = 20;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_FETCH = 3'd1,
        ST_REQ   = 3'd2,
        ST_ISSUE = 3'd3,
        ST_ERROR = 3'd4
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_fetch_if.sv
`default_nettype none
// ============================================================================
// Interface : seq_fetch_if
// Purpose   : Program-memory read channel between the fetch unit and memory.
// Revision  : 1.0
// ============================================================================
interface seq_fetch_if;
    import seq_pkg::*;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [INST_W-1:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );

endinterface
`default_nettype wire

// File: rtl/seq_fetch_line.sv
`default_nettype none
// ============================================================================
// Module   : seq_fetch_line
// Purpose  : One-entry tag/data/valid line buffer with compare, load and flush.
// Revision : 1.0
// ============================================================================
module seq_fetch_line
    import seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_cmp_tag,
    output logic              o_hit,
    output logic [INST_W-1:0] o_data,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_tag,
    input  logic [INST_W-1:0] i_load_data,
    input  logic              i_flush
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_tag;
    logic [INST_W-1:0] r_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else begin
            if (i_load) begin
                r_tag  <= i_load_tag;
                r_data <= i_load_data;
            end
            // A flush landing on the same edge as a fill leaves the line invalid.
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_load) begin
                r_valid <= 1'b1;
            end
        end
    end

    assign o_hit  = r_valid && (r_tag == i_cmp_tag);
    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/seq_fetch.sv
`default_nettype none
// ============================================================================
// Module   : seq_fetch
// Purpose  : Instruction fetch FSM with a one-entry line buffer and a
//            sticky program-memory timeout error.
// Revision : 1.0
// ============================================================================
module seq_fetch
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              flush,
    input  logic [ADDR_W-1:0] next,
    output logic [INST_W-1:0] inst,
    output logic              inst_en,
    output logic              error,
    seq_fetch_if.master       mem
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_fill;
    logic               w_line_hit;
    logic               w_hit_issue;
    logic [INST_W-1:0]  w_line_data;

    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [INST_W-1:0]  r_inst;
    logic               r_inst_en;
    logic               r_error;

    seq_fetch_line u_line (
        .clock       (clock),
        .reset       (reset),
        .i_cmp_tag   (next),
        .o_hit       (w_line_hit),
        .o_data      (w_line_data),
        .i_load      (w_fill),
        .i_load_tag  (r_mem_addr),
        .i_load_data (mem.mem_data),
        .i_flush     (flush)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_START;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fill      = 1'b0;
        w_hit_issue = 1'b0;
        case (r_state)
            ST_START: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (run) begin
                    if (w_line_hit && !flush) begin
                        w_hit_issue = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Ack is checked first so it wins over a simultaneous timeout.
                if (mem.mem_ack) begin
                    w_fill      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(TIMEOUT - 1)) begin
                        w_state_nxt = ST_ERROR;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_ERROR: begin
                w_state_nxt = ST_ERROR;
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_inst     <= '0;
            r_inst_en  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_mem_req <= (w_state_nxt == ST_REQ);
            r_inst_en <= (w_state_nxt == ST_ISSUE);
            r_error   <= (w_state_nxt == ST_ERROR);
            if (r_state == ST_FETCH && w_state_nxt == ST_REQ) begin
                r_mem_addr <= next;
            end
            if (w_fill) begin
                r_inst <= mem.mem_data;
            end else if (w_hit_issue) begin
                r_inst <= w_line_data;
            end
        end
    end

    assign mem.mem_req  = r_mem_req;
    assign mem.mem_addr = r_mem_addr;
    assign inst         = r_inst;
    assign inst_en      = r_inst_en;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_seq_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_fetch
// Purpose  : Self-checking bench for seq_fetch: memory responder, scoreboard
//            monitor and directed plus randomized instruction streams.
// Revision : 1.0
// ============================================================================
module tb_seq_fetch;
    import seq_pkg::*;

    logic              clock;
    logic              reset;
    logic              run;
    logic              flush;
    logic [ADDR_W-1:0] next;
    logic [INST_W-1:0] inst;
    logic              inst_en;
    logic              error;

    seq_fetch_if mem_bus ();

    seq_fetch #(.TIMEOUT(15)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .flush   (flush),
        .next    (next),
        .inst    (inst),
        .inst_en (inst_en),
        .error   (error),
        .mem     (mem_bus)
    );

    int          n_tests   = 0;
    int          n_fail    = 0;
    logic [INST_W-1:0] mem_img [256];
    logic [INST_W-1:0] exp_q [$];
    logic [INST_W-1:0] last_inst = '0;
    bit          ack_en    = 1'b1;
    bit          junk_en   = 1'b0;
    bit          force_ack = 1'b0;
    int          fixed_dly = -1;
    int          req_count = 0;
    int          prev_addr = -1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Program memory: counts requests and answers after 0..3 cycles.
    initial begin
        int dly;
        bit busy;
        bit prev_req;
        dly = 0; busy = 1'b0; prev_req = 1'b0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = '0;
        forever begin
            @(negedge clock);
            mem_bus.mem_ack  = 1'b0;
            mem_bus.mem_data = INST_W'($urandom);
            if (!reset) begin
                busy = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (mem_bus.mem_req && !prev_req) req_count++;
                prev_req = mem_bus.mem_req;
                if (force_ack) begin
                    mem_bus.mem_ack = 1'b1;
                end else if (mem_bus.mem_req && ack_en) begin
                    if (!busy) begin
                        busy = 1'b1;
                        dly  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                    end
                    if (dly == 0) begin
                        mem_bus.mem_ack  = 1'b1;
                        mem_bus.mem_data = mem_img[mem_bus.mem_addr];
                        busy = 1'b0;
                    end else begin
                        dly--;
                    end
                end else if (!mem_bus.mem_req) begin
                    busy = 1'b0;
                    if (junk_en && $urandom_range(0, 3) == 0) mem_bus.mem_ack = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge reset);
        last_inst = '0;
    end

    // Scoreboard monitor: every issued word must match the oldest expectation.
    initial forever begin
        @(negedge clock);
        if (reset) begin
            if (inst_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'(inst_en), 32'd0);
                end else begin
                    check("issued_word", 32'(inst), 32'(exp_q.pop_front()));
                end
                last_inst = inst;
            end else begin
                check("inst_hold", 32'(inst), 32'(last_inst));
            end
        end
    end

    task automatic wait_issue(input bit drop, input bit hold_flush, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (!hold_flush) flush = 1'b0;
            if (inst_en) seen = 1'b1;
            else if (drop && mem_bus.mem_req) run = 1'b0;
        end
        check("issue_within_budget", 32'(seen), 32'd1);
        run   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic issue_one(input logic [ADDR_W-1:0] addr, input bit fl, input bit drop, input int gap);
        int req0;
        bit miss;
        run = 1'b0;
        repeat (gap) @(negedge clock);
        miss = fl || (prev_addr != int'(addr));
        req0 = req_count;
        next = addr;
        run  = 1'b1;
        flush = fl;
        exp_q.push_back(mem_img[addr]);
        wait_issue(drop, 1'b0, 40);
        check("reads_per_instr", 32'(req_count - req0), miss ? 32'd1 : 32'd0);
        prev_addr = int'(addr);
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            if (mem_bus.mem_req) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        int req0;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < 256; i++) mem_img[i] = INST_W'($urandom);
        mem_img[0] = 20'h10123;
        reset = 1'b0; run = 1'b0; flush = 1'b0; next = '0;

        // Reset values, then first miss with ack one cycle after the request.
        repeat (3) @(negedge clock);
        check("rst_mem_req",  32'(mem_bus.mem_req),  32'd0);
        check("rst_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_inst",     32'(inst),             32'd0);
        check("rst_inst_en",  32'(inst_en),          32'd0);
        check("rst_error",    32'(error),            32'd0);
        run = 1'b1; next = 8'h00; fixed_dly = 1;
        exp_q.push_back(mem_img[0]);
        #2 reset = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            check("a_inst_en_timing", 32'(inst_en), (k == 4) ? 32'd1 : 32'd0);
            if (k == 2) begin
                check("a_mem_req",  32'(mem_bus.mem_req),  32'd1);
                check("a_mem_addr", 32'(mem_bus.mem_addr), 32'd0);
            end
            if (k == 4) begin
                check("a_inst", 32'(inst), 32'h10123);
                run = 1'b0;
            end
        end

        // Ack in the very first REQ cycle.
        @(negedge clock);
        fixed_dly = 0; next = 8'h05; run = 1'b1;
        exp_q.push_back(mem_img[5]);
        @(negedge clock);
        check("b_mem_req",  32'(mem_bus.mem_req),  32'd1);
        check("b_mem_addr", 32'(mem_bus.mem_addr), 32'd5);
        check("b_no_issue", 32'(inst_en),          32'd0);
        @(negedge clock);
        check("b_req_dropped", 32'(mem_bus.mem_req), 32'd0);
        check("b_issue",       32'(inst_en),         32'd1);
        run = 1'b0;
        @(negedge clock);
        check("b_issue_single", 32'(inst_en), 32'd0);

        // Jump-to-self: the second issue comes from the line, 2 cycles later.
        @(negedge clock);
        fixed_dly = -1; next = 8'h07; run = 1'b1; req0 = req_count;
        exp_q.push_back(mem_img[7]);
        exp_q.push_back(mem_img[7]);
        wait_issue(1'b0, 1'b0, 40);
        run = 1'b1;
        @(negedge clock);
        check("c_gap_no_issue", 32'(inst_en),         32'd0);
        check("c_gap_no_req",   32'(mem_bus.mem_req), 32'd0);
        @(negedge clock);
        check("c_hit_issue",  32'(inst_en),         32'd1);
        check("c_hit_no_req", 32'(mem_bus.mem_req), 32'd0);
        run = 1'b0;
        check("c_one_read", 32'(req_count - req0), 32'd1);

        // Flush in FETCH turns a would-be hit into a read.
        @(negedge clock);
        next = 8'h07; run = 1'b1; flush = 1'b1;
        exp_q.push_back(mem_img[7]);
        @(negedge clock);
        flush = 1'b0;
        check("d_mem_req",  32'(mem_bus.mem_req),  32'd1);
        check("d_mem_addr", 32'(mem_bus.mem_addr), 32'd7);
        wait_issue(1'b0, 1'b0, 40);

        // Flush held across the ack: word still issued, line left invalid.
        @(negedge clock);
        fixed_dly = 2; next = 8'h09; run = 1'b1; flush = 1'b1;
        exp_q.push_back(mem_img[9]);
        wait_issue(1'b0, 1'b1, 40);
        run = 1'b1; req0 = req_count;
        exp_q.push_back(mem_img[9]);
        @(negedge clock);
        check("e_fetch_no_issue", 32'(inst_en), 32'd0);
        @(negedge clock);
        check("e_refetch_req", 32'(mem_bus.mem_req), 32'd1);
        wait_issue(1'b0, 1'b0, 40);
        check("e_one_read", 32'(req_count - req0), 32'd1);
        prev_addr = 9; fixed_dly = -1;

        // Randomized stream with hits, flushes, run gaps and stray acks.
        junk_en = 1'b1;
        for (int n = 0; n < 120; n++) begin
            a = ($urandom_range(0, 2) == 0) ? 8'(prev_addr) : 8'($urandom_range(0, 7));
            issue_one(a, $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 2)));
        end

        // Timeout: 15 unanswered REQ cycles, then sticky error.
        junk_en = 1'b0; ack_en = 1'b0;
        @(negedge clock);
        next = 8'h33; run = 1'b1;
        wait_req("g_req_seen");
        run = 1'b0;
        check("g_no_error_yet", 32'(error), 32'd0);
        for (int i = 2; i <= 15; i++) begin
            @(negedge clock);
            check("g_req_holds", 32'({mem_bus.mem_req, error}), 32'b10);
        end
        @(negedge clock);
        check("g_error_set",   32'(error),           32'd1);
        check("g_req_dropped", 32'(mem_bus.mem_req), 32'd0);
        ack_en = 1'b1; junk_en = 1'b1; run = 1'b1; next = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check("g_error_absorbing", 32'({error, mem_bus.mem_req, inst_en}), 32'b100);
        end

        // Reset in the middle of a read, then a stray ack after release.
        #2 reset = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        junk_en = 1'b0; ack_en = 1'b0; next = 8'h44; run = 1'b1;
        wait_req("h_req_seen");
        #2 reset = 1'b0;
        #1;
        check("h_req_async_drop", 32'(mem_bus.mem_req), 32'd0);
        check("h_inst_cleared",   32'(inst),            32'd0);
        check("h_error_clear",    32'(error),           32'd0);
        run = 1'b0; force_ack = 1'b1;
        @(negedge clock);
        #2 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("h_quiet_after_reset", 32'({mem_bus.mem_req, inst_en}), 32'b00);
        end
        force_ack = 1'b0; ack_en = 1'b1; prev_addr = -1;

        // After reset the line is empty, so address 0 must be read again.
        junk_en = 1'b1;
        issue_one(8'h00, 1'b0, 1'b0, 1);
        for (int n = 0; n < 30; n++) begin
            a = 8'($urandom_range(0, 3));
            issue_one(a, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
                      int'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
